// File: rtl/aes_pkg.sv
// aes_pkg: shared AES byte-level definitions.
//   - aes_byte_t, affine constant, lane-count constants
//   - GF(2^8) helpers (poly x^8+x^4+x^3+x+1) used by the S-box datapath
//   - aes_sbox_f / aes_sbox_inv_f: table-free reference S-box built on
//     log/antilog arithmetic, intended for scoreboards rather than synthesis
package aes_pkg;

    typedef logic [7:0] aes_byte_t;

    localparam aes_byte_t AES_SBOX_AFFINE_C = 8'h63;
    localparam int        AES_LANES_STATE   = 16;
    localparam int        AES_LANES_WORD    = 4;

    function automatic aes_byte_t aes_gf_mul(input aes_byte_t a, input aes_byte_t b);
        aes_byte_t p;
        aes_byte_t x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Squaring is GF(2)-linear; synthesis flattens it to an XOR network.
    function automatic aes_byte_t aes_gf_sq(input aes_byte_t a);
        return aes_gf_mul(a, a);
    endfunction

    // Linear part of the forward affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4.
    function automatic aes_byte_t aes_fwd_lin(input aes_byte_t b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]};
    endfunction

    // Inverse of aes_fwd_lin: rotl1 ^ rotl3 ^ rotl6.
    function automatic aes_byte_t aes_inv_lin(input aes_byte_t b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]};
    endfunction

    // Multiplicative inverse via powers of the generator 0x03 (0 maps to 0).
    function automatic aes_byte_t aes_ref_inv(input aes_byte_t a);
        aes_byte_t e [0:254];
        aes_byte_t p;
        aes_byte_t r;
        int        lg;
        p  = 8'h01;
        lg = 0;
        r  = 8'h00;
        for (int k = 0; k < 255; k++) begin
            e[k] = p;
            if (p == a) lg = k;
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        if (a != 8'h00) r = e[(255 - lg) % 255];
        return r;
    endfunction

    function automatic aes_byte_t aes_sbox_f(input aes_byte_t a);
        aes_byte_t b;
        aes_byte_t s;
        b = aes_ref_inv(a);
        for (int i = 0; i < 8; i++)
            s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8]
                 ^ b[(i + 7) % 8] ^ AES_SBOX_AFFINE_C[i];
        return s;
    endfunction

    function automatic aes_byte_t aes_sbox_inv_f(input aes_byte_t s);
        aes_byte_t b;
        aes_byte_t d;
        d = 8'h05;
        for (int i = 0; i < 8; i++)
            b[i] = s[(i + 2) % 8] ^ s[(i + 5) % 8] ^ s[(i + 7) % 8] ^ d[i];
        return aes_ref_inv(b);
    endfunction

endpackage

// File: rtl/sbox_lane.sv
// sbox_lane: one byte of the forward/inverse S-box.
//   top  : input map (identity, or XOR 0x63 + inverse-affine) and x^16
//   core : N = x^17 (lies in GF(2^4)), inverted as N^14
//   bot  : y = x^16 * N^-1 = x^-1, then output map (affine + 0x63, or identity)
// Registers after top (PIPE_STAGES>=2) and after core (PIPE_STAGES==3);
// the output register is always present.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   ld[k]            load enable of stage k register (from the top's control)
//   top_inv          direction of the byte entering the top section
//   bot_inv          direction of the byte in the bottom section
//   din / dout       input byte / registered substituted byte
module sbox_lane
    import aes_pkg::*;
#(
    parameter int PIPE_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PIPE_STAGES-1:0] ld,
    input  logic                   top_inv,
    input  logic                   bot_inv,
    input  aes_byte_t              din,
    output aes_byte_t              dout
);

    aes_byte_t top_x, top_x16;
    aes_byte_t c_x, c_x16, c_ni;
    aes_byte_t b_x16, b_ni, b_out;
    aes_byte_t q;

    always_comb begin
        top_x   = top_inv ? aes_inv_lin(din ^ AES_SBOX_AFFINE_C) : din;
        top_x16 = aes_gf_sq(aes_gf_sq(aes_gf_sq(aes_gf_sq(top_x))));
    end

    // Every nonzero element of GF(2^4) satisfies N^15 = 1, so N^-1 = N^2*N^4*N^8.
    always_comb begin
        aes_byte_t n, n2, n4, n8;
        n    = aes_gf_mul(c_x16, c_x);
        n2   = aes_gf_sq(n);
        n4   = aes_gf_sq(n2);
        n8   = aes_gf_sq(n4);
        c_ni = aes_gf_mul(aes_gf_mul(n2, n4), n8);
    end

    always_comb begin
        aes_byte_t y;
        y     = aes_gf_mul(b_x16, b_ni);
        b_out = bot_inv ? y : (aes_fwd_lin(y) ^ AES_SBOX_AFFINE_C);
    end

    if (PIPE_STAGES == 1) begin : g_p1
        assign c_x   = top_x;
        assign c_x16 = top_x16;
        assign b_x16 = c_x16;
        assign b_ni  = c_ni;
    end else begin : g_pn
        aes_byte_t s0_x, s0_x16;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s0_x   <= '0;
                s0_x16 <= '0;
            end else if (ld[0]) begin
                s0_x   <= top_x;
                s0_x16 <= top_x16;
            end
        end
        assign c_x   = s0_x;
        assign c_x16 = s0_x16;

        if (PIPE_STAGES == 2) begin : g_p2
            assign b_x16 = c_x16;
            assign b_ni  = c_ni;
        end else begin : g_p3
            aes_byte_t s1_x16, s1_ni;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_x16 <= '0;
                    s1_ni  <= '0;
                end else if (ld[1]) begin
                    s1_x16 <= c_x16;
                    s1_ni  <= c_ni;
                end
            end
            assign b_x16 = s1_x16;
            assign b_ni  = s1_ni;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  q <= '0;
        else if (ld[PIPE_STAGES-1])  q <= b_out;
    end

    assign dout = q;

endmodule

// File: rtl/sbox_array_pipe.sv
// sbox_array_pipe: LANES independent S-box lanes behind a valid/ready pipeline.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   flush                   drops every in-flight transaction, blocks input
//   in_valid/in_ready       input handshake; in_inv selects inverse S-box
//   in_data[8*LANES]        byte i at [8i+7:8i]; in_tag rides alongside
//   out_valid/out_ready     output handshake
//   out_data, out_tag       registered result of the last stage
module sbox_array_pipe
    import aes_pkg::*;
#(
    parameter int LANES       = 16,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [8*LANES-1:0] in_data,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int LAST = PIPE_STAGES - 1;

    logic [PIPE_STAGES-1:0]            v, adv, ld;
    logic [PIPE_STAGES-1:0][TAG_W-1:0] tag_q;
    logic                              bot_inv;

    // Ready chain walked from the output back; a stage may advance when the
    // next one is empty or itself advancing.
    always_comb begin
        logic a;
        a = out_ready;
        for (int k = LAST; k >= 0; k--) begin
            adv[k] = a;
            a      = a || !v[k];
        end
    end

    assign in_ready = (!v[0] || adv[0]) && !flush;

    always_comb begin
        ld    = '0;
        ld[0] = in_valid && in_ready;
        for (int k = 1; k < PIPE_STAGES; k++) ld[k] = v[k-1] && adv[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v     <= '0;
            tag_q <= '0;
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++)
                v[k] <= !flush && (ld[k] || (v[k] && !adv[k]));
            if (ld[0]) tag_q[0] <= in_tag;
            for (int k = 1; k < PIPE_STAGES; k++)
                if (ld[k]) tag_q[k] <= tag_q[k-1];
        end
    end

    // Direction bits only exist for stages that still feed a direction-
    // dependent section; the output stage has all maps applied already.
    if (PIPE_STAGES == 1) begin : g_inv1
        assign bot_inv = in_inv;
    end else begin : g_invn
        logic [PIPE_STAGES-2:0] inv_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                inv_q <= '0;
            end else begin
                if (ld[0]) inv_q[0] <= in_inv;
                for (int k = 1; k < PIPE_STAGES - 1; k++)
                    if (ld[k]) inv_q[k] <= inv_q[k-1];
            end
        end
        assign bot_inv = inv_q[PIPE_STAGES-2];
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sbox_lane #(.PIPE_STAGES(PIPE_STAGES)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .ld      (ld),
            .top_inv (in_inv),
            .bot_inv (bot_inv),
            .din     (in_data[8*i +: 8]),
            .dout    (out_data[8*i +: 8])
        );
    end

    assign out_valid = v[LAST];
    assign out_tag   = tag_q[LAST];

endmodule
